// File: rtl/pri_enc_64b.sv
// Sequential 64-bit set-bit iterator: loads a request mask and streams out one set-bit index per valid/ready handshake.
// Optional build macro PRI_ENC_64B_ONEHOT_EN adds the onehot_o and mask_o observation ports.
module pri_enc_64b #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_i,
  input  logic [63:0] data_i,
  output logic        busy_o,
  output logic        idx_valid_o,
  input  logic        idx_ready_i,
  output logic [5:0]  idx_o,
  output logic        last_o,
  output logic [6:0]  cnt_o,
  output logic        done_o
`ifdef PRI_ENC_64B_ONEHOT_EN
  ,
  output logic [63:0] onehot_o,
  output logic [63:0] mask_o
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] mask_q, mask_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  logic [5:0]  ffs_idx;
  logic [63:0] ffs_onehot;
  logic        single_bit;
  logic [6:0]  pop_cnt;

  // The last match found in the loop wins, so the loop runs opposite to the priority order.
  always_comb begin
    ffs_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 64; i++) begin
        if (mask_q[i]) ffs_idx = 6'(i);
      end
    end else begin
      for (int i = 63; i >= 0; i--) begin
        if (mask_q[i]) ffs_idx = 6'(i);
      end
    end
  end

  assign ffs_onehot = 64'd1 << ffs_idx;
  assign single_bit = (mask_q != 64'd0) && ((mask_q & (mask_q - 64'd1)) == 64'd0);

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < 64; i++) begin
      pop_cnt = pop_cnt + 7'(data_i[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_i) begin
          mask_d = data_i;
          cnt_d  = pop_cnt;
          if (data_i != 64'd0) state_d = SEND;
          else                 done_d  = 1'b1;
        end
      end
      SEND: begin
        if (idx_ready_i) begin
          // Clearing the final bit leaves mask_d at zero, so the drain needs no separate clear.
          mask_d = mask_q & ~ffs_onehot;
          if (single_bit) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy_o      = (state_q == SEND);
  assign idx_valid_o = (state_q == SEND);
  assign idx_o       = ffs_idx;
  assign last_o      = single_bit;
  assign cnt_o       = cnt_q;
  assign done_o      = done_q;

`ifdef PRI_ENC_64B_ONEHOT_EN
  assign onehot_o = (state_q == SEND) ? ffs_onehot : 64'd0;
  assign mask_o   = mask_q;
`endif

endmodule

// File: tb/tb_pri_enc_64b.sv
// Self-checking bench for pri_enc_64b: randomized loads and ready patterns, scoreboard queues
// filled by the driver from a list-based model and drained by an independent output monitor.
module tb_pri_enc_64b;

  localparam bit MSB = 1'b0;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        init_i;
  logic [63:0] data_i;
  logic        busy_o;
  logic        idx_valid_o;
  logic        idx_ready_i;
  logic [5:0]  idx_o;
  logic        last_o;
  logic [6:0]  cnt_o;
  logic        done_o;
`ifdef PRI_ENC_64B_ONEHOT_EN
  logic [63:0] onehot_o;
  logic [63:0] mask_o;
  logic [63:0] model_mask = '0;
`endif

  pri_enc_64b #(.MSB_FIRST(MSB)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .init_i      (init_i),
    .data_i      (data_i),
    .busy_o      (busy_o),
    .idx_valid_o (idx_valid_o),
    .idx_ready_i (idx_ready_i),
    .idx_o       (idx_o),
    .last_o      (last_o),
    .cnt_o       (cnt_o),
    .done_o      (done_o)
`ifdef PRI_ENC_64B_ONEHOT_EN
    ,
    .onehot_o    (onehot_o),
    .mask_o      (mask_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [5:0] idx;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string name);
    logic [63:0] act;
    act = 64'({busy_o, idx_valid_o, idx_o, last_o, cnt_o, done_o});
    chk(act == 64'd0, name, act, 64'd0);
  endtask

  // Reference: the ordered list of set-bit positions; the final one carries last.
  task automatic model_push(input logic [63:0] d);
    int total, n;
    total = $countones(d);
    n = 0;
    for (int k = 0; k < 64; k++) begin
      int i;
      i = MSB ? 63 - k : k;
      if (d[i]) begin
        n++;
        exp_q.push_back('{idx: 6'(i), last: (n == total)});
      end
    end
    done_q.push_back(total);
`ifdef PRI_ENC_64B_ONEHOT_EN
    model_mask = d;
`endif
  endtask

  // Called at posedge+1 with the block idle; returns at posedge+1 of the first cycle after the load.
  task automatic drive_load(input logic [63:0] d);
    init_i = 1'b1;
    data_i = d;
    model_push(d);
    @(posedge clk_i);
    #1;
    init_i = 1'b0;
    data_i = {$urandom, $urandom};
    chk(idx_valid_o == (d != 64'd0), "load_valid_latency", 64'(idx_valid_o), 64'(d != 64'd0));
    chk(done_o == (d == 64'd0), "empty_done_latency", 64'(done_o), 64'(d == 64'd0));
  endtask

  // mode 0: ready always high; 1: ready low for 'stall' cycles per index; 2: random ready.
  task automatic drain(input int mode, input int stall, input int inj_at, output int vcyc);
    int st;
    bit finished;
    st = 0;
    vcyc = 0;
    finished = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!idx_valid_o) begin
        finished = 1'b1;
        break;
      end
      vcyc++;
      case (mode)
        0:       idx_ready_i = 1'b1;
        1:       idx_ready_i = (st >= stall);
        default: idx_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (idx_ready_i) st = 0;
      else             st++;
      if (c == inj_at) begin
        init_i = 1'b1;
        data_i = 64'h1;
      end else begin
        init_i = 1'b0;
      end
      @(posedge clk_i);
      #1;
    end
    init_i = 1'b0;
    idx_ready_i = 1'b0;
    if (!finished) chk(1'b0, "drain_timeout", 64'(vcyc), 64'd0);
  endtask

  // Monitor: samples on the falling edge, between driver updates and DUT updates.
  initial begin : monitor
    bit         hold_pending;
    logic [6:0] held;
    hold_pending = 1'b0;
    held = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        hold_pending = 1'b0;
      end else begin
        chk(busy_o == idx_valid_o, "busy_tracks_valid", 64'(busy_o), 64'(idx_valid_o));
`ifdef PRI_ENC_64B_ONEHOT_EN
        chk(mask_o == model_mask, "mask_o", mask_o, model_mask);
        if (!idx_valid_o) chk(onehot_o == 64'd0, "onehot_idle", onehot_o, 64'd0);
`endif
        if (idx_valid_o) begin
          chk(exp_q.size() != 0, "valid_without_expectation", 64'(idx_o), 64'd0);
          if (hold_pending)
            chk({idx_o, last_o} == held, "stall_stable", 64'({idx_o, last_o}), 64'(held));
          if (exp_q.size() != 0) begin
`ifdef PRI_ENC_64B_ONEHOT_EN
            chk(onehot_o == (64'd1 << exp_q[0].idx), "onehot_o", onehot_o, 64'd1 << exp_q[0].idx);
`endif
            if (idx_ready_i) begin
              exp_t e;
              e = exp_q.pop_front();
              chk({idx_o, last_o} == {e.idx, e.last}, "idx_last", 64'({idx_o, last_o}), 64'({e.idx, e.last}));
`ifdef PRI_ENC_64B_ONEHOT_EN
              model_mask[e.idx] = 1'b0;
`endif
              hold_pending = 1'b0;
            end else begin
              hold_pending = 1'b1;
              held = {idx_o, last_o};
            end
          end
        end else begin
          hold_pending = 1'b0;
        end
        if (done_o) begin
          chk(done_q.size() != 0, "unexpected_done", 64'(done_o), 64'd0);
          if (done_q.size() != 0) begin
            int n;
            n = done_q.pop_front();
            chk(cnt_o == 7'(n), "cnt_at_done", 64'(cnt_o), 64'(n));
          end
        end
      end
    end
  end

  initial begin : driver
    int vc;
    logic [63:0] w;
    rst_i = 1'b1;
    init_i = 1'b0;
    data_i = '0;
    idx_ready_i = 1'b0;
    #12;
    check_zero("reset_outputs");
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    drive_load(64'd0);
    chk(cnt_o == 7'd0, "empty_cnt", 64'(cnt_o), 64'd0);
    @(posedge clk_i);
    #1;
    chk(idx_valid_o == 1'b0 && done_o == 1'b0, "empty_after", 64'({idx_valid_o, done_o}), 64'd0);

    drive_load(64'd1 << 37);
    drain(0, 0, -1, vc);
    chk(vc == 1, "single_bit_cycles", 64'(vc), 64'd1);
    chk(cnt_o == 7'd1, "single_bit_cnt", 64'(cnt_o), 64'd1);

    drive_load(64'h8000_0000_0000_0011);
    drain(0, 0, -1, vc);
    chk(vc == 3, "ordered_cycles", 64'(vc), 64'd3);

    drive_load(64'h8000_0000_0000_0011);
    drain(1, 3, -1, vc);
    chk(vc == 12, "backpressure_cycles", 64'(vc), 64'd12);

    drive_load('1);
    chk(cnt_o == 7'd64, "full_cnt", 64'(cnt_o), 64'd64);
    drain(0, 0, 10, vc);
    chk(vc == 64, "full_cycles", 64'(vc), 64'd64);
    chk(cnt_o == 7'd64, "full_cnt_after_ignored_load", 64'(cnt_o), 64'd64);

    // Back-to-back loads: each load lands in the done cycle of the previous word.
    for (int t = 0; t < 24; t++) begin
      case (t % 4)
        0:       w = {$urandom, $urandom};
        1:       w = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        2:       w = (t % 8 == 2) ? 64'd0 : (64'd1 << $urandom_range(0, 63));
        default: w = ~({$urandom, $urandom} & {$urandom, $urandom});
      endcase
      drive_load(w);
      drain((t % 3 == 0) ? 0 : 2, 0, -1, vc);
      if (t % 3 == 0) chk(vc == $countones(w), "b2b_cycles", 64'(vc), 64'($countones(w)));
    end

    // Asynchronous reset after five transfers.
    drive_load({$urandom, $urandom} | 64'h0000_0F00_00F0_00FF);
    idx_ready_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check_zero("async_reset_outputs");
    exp_q.delete();
    done_q.delete();
`ifdef PRI_ENC_64B_ONEHOT_EN
    model_mask = '0;
`endif
    idx_ready_i = 1'b0;
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("post_reset_idle");

    w = {$urandom, $urandom} | 64'h1;
    drive_load(w);
    drain(0, 0, -1, vc);
    chk(vc == $countones(w), "post_reset_cycles", 64'(vc), 64'($countones(w)));

    repeat (3) @(posedge clk_i);
    #1;
    chk(exp_q.size() == 0, "idx_queue_drained", 64'(exp_q.size()), 64'd0);
    chk(done_q.size() == 0, "done_queue_drained", 64'(done_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pri_enc_64b.md
# pri_enc_64b

Sequential 64-bit set-bit iterator: loads a 64-bit request mask and streams out the 6-bit index of every set bit, one per handshake, in priority order. It is the consumer-side counterpart of the one-hot priority isolator: it turns a request vector into a stream of binary grant indices for downstream arbiters and schedulers. It is built from a registered mask, a find-first-set plus clear loop, and a two-state FSM with a valid/ready output handshake.

## Interface
- MSB_FIRST, 1'b0, scan order: 0 emits lowest set index first; 1 emits highest set index first.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- init_i  input  1  load strobe; samples data_i when the block is idle.
- data_i  input  64  request mask to iterate.
- busy_o  output  1  high while the FSM is in SEND.
- idx_valid_o  output  1  idx_o/last_o are valid.
- idx_ready_i  input  1  downstream accepts the current index.
- idx_o  output  6  index of the current highest-priority set bit.
- last_o  output  1  current index is the final set bit of the word.
- cnt_o  output  7  popcount of the last loaded word (0..64).
- done_o  output  1  one-cycle pulse when a word is fully drained, or when an empty word is loaded.

## Operation
- Reset values: every output is 0, mask_r=0, FSM in IDLE, and cnt_o=0.
- IDLE state:
  - When init_i=1: mask_r<=data_i and cnt_o<=popcount(data_i).
  - If data_i≠0, go to SEND.
  - If data_i=0, stay in IDLE and pulse done_o on the next cycle.
- SEND state:
  - idx_valid_o=1 and busy_o=1.
  - idx_o is the find-first-set of mask_r in MSB_FIRST order.
  - last_o=1 when exactly one bit of mask_r is set.
- Handshake: a transfer occurs when idx_valid_o and idx_ready_i are both high at a rising edge.
  - On a transfer, the bit at idx_o is cleared in mask_r.
  - If last_o was high: go to IDLE, done_o=1 for the following cycle, and mask_r becomes 0.
- Backpressure: while idx_valid_o=1 and idx_ready_i=0, idx_o and last_o hold stable.
- init_i while in SEND is ignored. mask_r and cnt_o are unchanged.
- init_i on the same cycle as the done_o pulse is accepted, because the FSM is already in IDLE.
- cnt_o holds its value until the next accepted load.
- No combinational path from data_i or init_i to any output. idx_o and last_o decode only mask_r. idx_valid_o follows idx_ready_i only through state.
- rst_i asserted mid-stream aborts immediately. All state returns to reset values. No done_o pulse is generated.

## Timing
- Load latency: init_i high at edge N puts idx_valid_o high with the first index in cycle N+1.
- Throughput: one index per cycle while idx_ready_i is held high. A word with k set bits drains in k cycles after the load.
- done_o is asserted in the cycle after the final transfer, for exactly 1 cycle.
- Empty load: init_i with data_i=0 at edge N gives done_o=1 in cycle N+1. idx_valid_o never rises.
- Back-to-back words: the minimum period is k+1 cycles per word. The idle cycle is the done_o cycle, in which init_i is accepted.
- Full word: data_i=all ones gives cnt_o=64 and exactly 64 transfers. last_o is high only on index 63 (or index 0 when MSB_FIRST=1).

## Configuration
- Macro: PRI_ENC_64B_ONEHOT_EN.
- Defined:
  - Adds output port onehot_o [63:0], the one-hot of the current index, valid with idx_valid_o and otherwise 0.
  - Adds output port mask_o [63:0], the remaining undrained bits (mask_r). It is 0 after reset and after drain.
- Undefined: neither port exists. Behaviour of every other port is identical in both builds.

## Test plan
- Reset and empty load: after reset all outputs are 0. Then init_i with data_i=0 gives done_o=1 one cycle later, cnt_o=0, and no idx_valid_o.
- Single bit: data_i=1<<37 with ready=1 gives one transfer with idx_o=37 and last_o=1, then done_o on the next cycle and cnt_o=1.
- Ordered drain with MSB_FIRST=0: data_i=0x8000_0000_0000_0011 gives idx_o sequence 0, 4, 63, with last_o only on 63 and cnt_o=3.
- Backpressure: same word with idx_ready_i low for 3 cycles on each index gives idx_o/last_o stable while stalled, the same sequence, and 12 cycles total.
- Full word and ignore-while-busy: data_i=all ones, with init_i pulsed mid-drain using data_i=0x1. Expected: 64 transfers 0..63, cnt_o stays 64, the second load is ignored, and done_o fires once.
- Async reset mid-stream: rst_i asserted after 5 transfers clears all outputs without waiting for a clock edge. There is no done_o, and a subsequent load works normally.
